im_sram_loader: RTL and testbench
=================================

// Module: im_sram_loader
// PURPOSE
//  Streams folded item-memory (IM) hypervector words into the IM SRAM write port of hdc_sensor_fusion.
//  Replaces bench-driven direct writes with an in-design loader that takes a valid/ready source.
//  Supports runtime-selectable input ordering (fold-major or channel-major), a base address and a
//  completion flag. SRAM layout is always fold-major: addr = BASE_ADDR + f*NUM_CHANNELS + c.
// PARAMETERS
//  NUM_CHANNELS     214   IM channels (TOTAL_NUM_CHANNEL)
//  NUM_FOLDS        4     folds per hypervector; HV_DIMENSION must be a multiple of it
//  FOLD_WIDTH       500   bits per fold word (HV_DIMENSION/NUM_FOLDS)
//  SRAM_ADDR_WIDTH  10    SRAM address width; BASE_ADDR+NUM_CHANNELS*NUM_FOLDS <= 2**SRAM_ADDR_WIDTH
//  BASE_ADDR        0     first SRAM address written
// PORTS
//  clk            in   1                 clock, all logic on posedge
//  rst            in   1                 synchronous, active-high reset
//  start          in   1                 1-cycle pulse: begin (or restart) a load
//  order_ch_major in   1                 sampled at start: 0 = input is fold-major, 1 = channel-major
//  in_valid       in   1                 source word valid
//  in_ready       out  1                 loader accepts a word this cycle
//  in_data        in   FOLD_WIDTH        fold word
//  we             out  1                 SRAM write enable, ACTIVE-LOW (0 = write)
//  im_write_addr  out  SRAM_ADDR_WIDTH   SRAM write address
//  im_din         out  FOLD_WIDTH        SRAM write data
//  load_done      out  1                 all NUM_CHANNELS*NUM_FOLDS words written
//  word_count     out  ceilLog2(N*F+1)   words accepted in current load
// BEHAVIOUR
//  - Reset: state IDLE, we=1, im_write_addr=0, im_din=0, in_ready=0, load_done=0, word_count=0,
//    channel/fold counters 0. Reset mid-load abandons the load at the same edge (no further writes).
//  - FSM IDLE -> LOAD on start. LOAD -> DONE when the last word is accepted. DONE -> LOAD on start.
//    LOAD -> LOAD (restart) on start: counters and word_count cleared, order re-sampled,
//    load_done=0, and no word is accepted in the start cycle (in_ready forced 0 that cycle).
//  - in_ready = (state==LOAD) & ~start. Transfer = in_valid & in_ready; no buffering, no back-pressure
//    from SRAM (SRAM accepts a write every cycle).
//  - Write latency 1 cycle: on the edge that takes a transfer, register we=0,
//    im_write_addr=BASE_ADDR+f*NUM_CHANNELS+c, im_din=in_data. Any cycle without a transfer
//    registers we=1; im_write_addr/im_din hold their last values.
//  - Counters (c,f) advance per transfer. order_ch_major=0: c increments, wraps at NUM_CHANNELS-1
//    to 0 and then f increments. order_ch_major=1: f increments, wraps at NUM_FOLDS-1 to 0 and then c
//    increments. Terminal word is (c=NUM_CHANNELS-1, f=NUM_FOLDS-1) in both orders.
//  - Address math done at SRAM_ADDR_WIDTH bits, no overflow given the parameter constraint;
//    multiply f*NUM_CHANNELS realised as a running fold-base accumulator (add NUM_CHANNELS on f++).
//  - word_count increments per transfer, saturates at NUM_CHANNELS*NUM_FOLDS.
//  - load_done rises the cycle after the terminal transfer (same edge its write is registered as
//    we=0, i.e. load_done and the final we=0 are visible together), stays 1 in DONE until start/rst.
//  - In IDLE/DONE, in_valid is ignored and we stays 1.
//  - start in the same cycle as the terminal transfer: start wins; in_ready is 0, so no transfer.
// TESTING
//  - Reset then idle 10 cycles with in_valid=1 -> we=1, in_ready=0, load_done=0 throughout.
//  - Defaults, order=0, 856 back-to-back words with data=index -> write k at addr k, data k;
//    856 we=0 pulses; load_done=1 with final write addr 855; word_count=856.
//  - N=3,F=2, order=1, words 0..5 -> addrs 0,3,1,4,2,5; load_done after 6th write.
//  - in_valid toggled 1/0 randomly, BASE_ADDR=100 -> writes only on transfers, addrs 100..955 in
//    order, we=1 on every non-transfer cycle.
//  - start pulse after 300 words -> in_ready=0 that cycle, word_count=0, next write at BASE_ADDR,
//    load completes after 856 further words.
//  - rst asserted after 50 words -> next edge we=1, in_ready=0, no writes until new start.

Source files
------------

// File: rtl/im_sram_loader_if.sv
// Source-word handshake and IM SRAM write port bundle
// for the item-memory loader.
interface im_sram_loader_if #(
  parameter int FOLD_WIDTH      = 500,
  parameter int SRAM_ADDR_WIDTH = 10
);
  logic                       in_valid;
  logic                       in_ready;
  logic [FOLD_WIDTH-1:0]      in_data;
  logic                       we;
  logic [SRAM_ADDR_WIDTH-1:0] im_write_addr;
  logic [FOLD_WIDTH-1:0]      im_din;

  modport master (
    output in_valid, in_data,
    input  in_ready, we, im_write_addr, im_din
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, we, im_write_addr, im_din
  );
endinterface

// File: rtl/im_sram_loader.sv
// Streams folded IM words from a valid/ready source into the
// IM SRAM write port, always in fold-major address layout.
module im_sram_loader #(
  parameter int NUM_CHANNELS    = 214,
  parameter int NUM_FOLDS       = 4,
  parameter int FOLD_WIDTH      = 500,
  parameter int SRAM_ADDR_WIDTH = 10,
  parameter int BASE_ADDR       = 0,
  localparam int TOTAL = NUM_CHANNELS * NUM_FOLDS,
  localparam int CNT_W = $clog2(TOTAL + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             order_ch_major,
  im_sram_loader_if.slave  bus,
  output logic             load_done,
  output logic [CNT_W-1:0] word_count
);
  localparam int AW   = SRAM_ADDR_WIDTH;
  localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int FD_W = (NUM_FOLDS > 1) ? $clog2(NUM_FOLDS) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_e;

  state_e                state_q;
  logic [CH_W-1:0]       c_q, c_d;
  logic [FD_W-1:0]       f_q, f_d;
  logic [AW-1:0]         fbase_q, fbase_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [FOLD_WIDTH-1:0] din_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  order_q, we_q, done_q;
  logic                  xfer, last_c, last_f, term;

  assign bus.in_ready = (state_q == LOAD) & ~start;
  assign xfer   = bus.in_valid & bus.in_ready;
  assign last_c = (c_q == CH_W'(NUM_CHANNELS - 1));
  assign last_f = (f_q == FD_W'(NUM_FOLDS - 1));
  assign term   = last_c & last_f;

  // fbase_q tracks f*NUM_CHANNELS so no multiplier is needed
  assign addr_d = AW'(BASE_ADDR) + fbase_q + AW'(c_q);

  always_comb begin
    c_d     = c_q;
    f_d     = f_q;
    fbase_d = fbase_q;
    if (!order_q) begin
      if (last_c) begin
        c_d     = '0;
        f_d     = f_q + 1'b1;
        fbase_d = fbase_q + AW'(NUM_CHANNELS);
      end else begin
        c_d = c_q + 1'b1;
      end
    end else begin
      if (last_f) begin
        f_d     = '0;
        fbase_d = '0;
        c_d     = c_q + 1'b1;
      end else begin
        f_d     = f_q + 1'b1;
        fbase_d = fbase_q + AW'(NUM_CHANNELS);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      c_q     <= '0;
      f_q     <= '0;
      fbase_q <= '0;
      order_q <= 1'b0;
      we_q    <= 1'b1;
      addr_q  <= '0;
      din_q   <= '0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      we_q <= ~xfer;
      if (start) begin
        state_q <= LOAD;
        c_q     <= '0;
        f_q     <= '0;
        fbase_q <= '0;
        order_q <= order_ch_major;
        done_q  <= 1'b0;
        cnt_q   <= '0;
      end else if (xfer) begin
        addr_q  <= addr_d;
        din_q   <= bus.in_data;
        c_q     <= c_d;
        f_q     <= f_d;
        fbase_q <= fbase_d;
        if (cnt_q != CNT_W'(TOTAL))
          cnt_q <= cnt_q + 1'b1;
        if (term) begin
          state_q <= DONE;
          done_q  <= 1'b1;
        end
      end
    end
  end

  assign bus.we            = we_q;
  assign bus.im_write_addr = addr_q;
  assign bus.im_din        = din_q;
  assign load_done         = done_q;
  assign word_count        = cnt_q;
endmodule

// File: tb/tb_im_sram_loader.sv
// Directed bench for im_sram_loader: default geometry, a tiny
// 3x2 geometry driven from a vector table, and an offset base.
module tb_im_sram_loader;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int wr0    = 0;

  logic rst0, rst1, rst2;
  logic st0, st1, st2;
  logic ord0, ord1, ord2;
  logic done0, done1, done2;
  logic [9:0] wc0, wc2;
  logic [2:0] wc1;

  im_sram_loader_if #(.FOLD_WIDTH(500), .SRAM_ADDR_WIDTH(10)) if0();
  im_sram_loader_if #(.FOLD_WIDTH(8),   .SRAM_ADDR_WIDTH(10)) if1();
  im_sram_loader_if #(.FOLD_WIDTH(16),  .SRAM_ADDR_WIDTH(10)) if2();

  im_sram_loader u0 (
    .clk(clk), .rst(rst0), .start(st0), .order_ch_major(ord0),
    .bus(if0), .load_done(done0), .word_count(wc0)
  );

  im_sram_loader #(
    .NUM_CHANNELS(3), .NUM_FOLDS(2), .FOLD_WIDTH(8),
    .SRAM_ADDR_WIDTH(10), .BASE_ADDR(0)
  ) u1 (
    .clk(clk), .rst(rst1), .start(st1), .order_ch_major(ord1),
    .bus(if1), .load_done(done1), .word_count(wc1)
  );

  im_sram_loader #(
    .NUM_CHANNELS(214), .NUM_FOLDS(4), .FOLD_WIDTH(16),
    .SRAM_ADDR_WIDTH(10), .BASE_ADDR(100)
  ) u2 (
    .clk(clk), .rst(rst2), .start(st2), .order_ch_major(ord2),
    .bus(if2), .load_done(done2), .word_count(wc2)
  );

  always @(negedge clk)
    if (if0.we === 1'b0) wr0 <= wr0 + 1;

  typedef struct {
    int st, ord, vld, dat;
    int rdy, we, addr, din, done, wc;
  } vec_t;

  vec_t tbl [21];

  task automatic chk(input string nm,
                     input logic [511:0] act,
                     input logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drv0(input logic s, input logic v, input int d);
    st0 = s;
    if0.in_valid = v;
    if0.in_data  = 500'(d);
    @(posedge clk);
    #1;
  endtask

  task automatic load0(input int from, input int to, input string nm);
    for (int k = from; k < to; k++) begin
      st0 = 1'b0;
      if0.in_valid = 1'b1;
      if0.in_data  = 500'(k);
      if (k == from) begin
        #1;
        chk({nm, " rdy"}, 512'(if0.in_ready), 512'(1));
      end
      @(posedge clk);
      #1;
      chk(nm, 512'({if0.we, if0.im_write_addr, if0.im_din}),
          512'({1'b0, 10'(k), 500'(k)}));
    end
  endtask

  initial begin
    int w, k, cyc;
    logic v;

    tbl[0]  = '{1,1,1, 0, 0,1,0, 0,0,0};
    tbl[1]  = '{0,0,1,10, 1,0,0,10,0,1};
    tbl[2]  = '{0,0,1,11, 1,0,3,11,0,2};
    tbl[3]  = '{0,0,1,12, 1,0,1,12,0,3};
    tbl[4]  = '{0,0,0,99, 1,1,1,12,0,3};
    tbl[5]  = '{0,0,1,13, 1,0,4,13,0,4};
    tbl[6]  = '{0,0,1,14, 1,0,2,14,0,5};
    tbl[7]  = '{0,0,1,15, 1,0,5,15,1,6};
    tbl[8]  = '{0,0,1,16, 0,1,5,15,1,6};
    tbl[9]  = '{1,0,1,17, 0,1,5,15,0,0};
    tbl[10] = '{0,0,1,20, 1,0,0,20,0,1};
    tbl[11] = '{0,0,1,21, 1,0,1,21,0,2};
    tbl[12] = '{0,0,1,22, 1,0,2,22,0,3};
    tbl[13] = '{1,0,1,23, 0,1,2,22,0,0};
    tbl[14] = '{0,0,1,30, 1,0,0,30,0,1};
    tbl[15] = '{0,0,1,31, 1,0,1,31,0,2};
    tbl[16] = '{0,0,1,32, 1,0,2,32,0,3};
    tbl[17] = '{0,0,1,33, 1,0,3,33,0,4};
    tbl[18] = '{0,0,1,34, 1,0,4,34,0,5};
    tbl[19] = '{1,0,1,35, 0,1,4,34,0,0};
    tbl[20] = '{0,0,1,40, 1,0,0,40,0,1};

    rst0 = 1; rst1 = 1; rst2 = 1;
    st0 = 0; st1 = 0; st2 = 0;
    ord0 = 0; ord1 = 0; ord2 = 0;
    if0.in_valid = 0; if0.in_data = '0;
    if1.in_valid = 0; if1.in_data = '0;
    if2.in_valid = 0; if2.in_data = '0;
    repeat (2) @(posedge clk);
    #1;

    chk("u0 reset", 512'({if0.we, if0.in_ready, done0, wc0,
                          if0.im_write_addr, if0.im_din}),
        512'({1'b1, 1'b0, 1'b0, 10'd0, 10'd0, 500'd0}));
    chk("u1 reset", 512'({if1.we, if1.in_ready, done1, wc1,
                          if1.im_write_addr, if1.im_din}),
        512'({1'b1, 1'b0, 1'b0, 3'd0, 10'd0, 8'd0}));
    rst0 = 0; rst1 = 0; rst2 = 0;

    for (int i = 0; i < 10; i++) begin
      drv0(1'b0, 1'b1, 500 + i);
      chk("u0 idle", 512'({if0.we, if0.in_ready, done0}),
          512'(3'b100));
    end

    ord0 = 0;
    drv0(1'b1, 1'b0, 0);
    w = wr0;
    load0(0, 855, "u0 load");
    chk("u0 early done", 512'(done0), 512'(0));
    load0(855, 856, "u0 load");
    chk("u0 done", 512'({done0, wc0}), 512'({1'b1, 10'd856}));
    drv0(1'b0, 1'b1, 999);
    chk("u0 done hold", 512'({if0.we, if0.in_ready, done0, wc0}),
        512'({1'b1, 1'b0, 1'b1, 10'd856}));
    chk("u0 write pulses", 512'(wr0 - w), 512'(856));

    drv0(1'b1, 1'b0, 0);
    load0(0, 300, "u0 pre-restart");
    st0 = 1; if0.in_valid = 1; if0.in_data = 500'(777);
    #1;
    chk("u0 restart rdy", 512'(if0.in_ready), 512'(0));
    @(posedge clk);
    #1;
    chk("u0 restart", 512'({if0.we, done0, wc0}),
        512'({1'b1, 1'b0, 10'd0}));
    load0(0, 856, "u0 reload");
    chk("u0 reload done", 512'({done0, wc0}), 512'({1'b1, 10'd856}));

    drv0(1'b1, 1'b0, 0);
    load0(0, 50, "u0 pre-rst");
    rst0 = 1;
    drv0(1'b0, 1'b1, 50);
    chk("u0 mid rst", 512'({if0.we, if0.in_ready, done0, wc0}),
        512'({1'b1, 1'b0, 1'b0, 10'd0}));
    rst0 = 0;
    for (int i = 0; i < 5; i++) begin
      drv0(1'b0, 1'b1, 51 + i);
      chk("u0 post rst", 512'({if0.we, if0.in_ready}), 512'(2'b10));
    end

    for (int i = 0; i < 21; i++) begin
      st1 = tbl[i].st[0];
      ord1 = tbl[i].ord[0];
      if1.in_valid = tbl[i].vld[0];
      if1.in_data  = 8'(tbl[i].dat);
      #1;
      chk($sformatf("u1 rdy %0d", i), 512'(if1.in_ready),
          512'(tbl[i].rdy));
      @(posedge clk);
      #1;
      chk($sformatf("u1 out %0d", i),
          512'({if1.we, if1.im_write_addr, if1.im_din, done1, wc1}),
          512'({1'(tbl[i].we), 10'(tbl[i].addr), 8'(tbl[i].din),
                1'(tbl[i].done), 3'(tbl[i].wc)}));
    end
    st1 = 0;

    ord2 = 0; st2 = 1;
    @(posedge clk);
    #1;
    st2 = 0;
    k = 0;
    cyc = 0;
    while (k < 856 && cyc < 5000) begin
      v = 1'($urandom_range(0, 1));
      if2.in_valid = v;
      if2.in_data  = 16'(k);
      #1;
      chk("u2 rdy", 512'(if2.in_ready), 512'(1));
      @(posedge clk);
      #1;
      if (v) begin
        chk("u2 write", 512'({if2.we, if2.im_write_addr, if2.im_din}),
            512'({1'b0, 10'(100 + k), 16'(k)}));
        k++;
      end else begin
        chk("u2 idle we", 512'(if2.we), 512'(1));
      end
      cyc++;
    end
    chk("u2 words", 512'(k), 512'(856));
    chk("u2 done", 512'({done2, wc2}), 512'({1'b1, 10'd856}));
    if2.in_valid = 0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
